// File: rtl/aes_pkg.sv
// AES-128 helper package shared by the encryption pipeline.
// Contents: forward S-box, round constants, and the byte/word/state
// transforms (xtime, SubBytes, ShiftRows, MixColumns, key expansion step).
// State and key layout: bit 127 is byte 0; byte i lives in [127-8i -: 8];
// column c is bytes 4c..4c+3 (FIPS-197 column-major order).
package aes_pkg;

    // Element 0 is the leftmost byte of the literal, so SBOX[x] is S(x).
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // RCON[r-1] is the round constant for round r.
    localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 4; i++) begin
            o[32*i +: 32] = sub_word(s[32*i +: 32]);
        end
        return o;
    endfunction

    // Row r of the state rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        {a0, a1, a2, a3} = col;
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32*c -: 32] = mix_column(s[127 - 32*c -: 32]);
        end
        return o;
    endfunction

    // Derive round key r from round key r-1 (rc = Rcon[r]).
    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        logic [31:0] n0, n1, n2, n3;
        {w0, w1, w2, w3} = k;
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

endpackage

// File: rtl/aes_round_stage.sv
// One registered AES round.
// Parameters: ROUND (1..10) selects the round constant; FINAL_ROUND drops
// MixColumns for the last round.
// Ports: clk, reset (async active-low), state_in / round_key_in from the
// previous stage register, state_out / round_key_out registered for the next.
module aes_round_stage
    import aes_pkg::*;
#(
    parameter int ROUND       = 1,
    parameter bit FINAL_ROUND = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] state_in,
    input  logic [127:0] round_key_in,
    output logic [127:0] state_out,
    output logic [127:0] round_key_out
);

    logic [127:0] rk_next;
    logic [127:0] shifted;
    logic [127:0] mixed;

    always_comb begin
        rk_next = key_step(round_key_in, RCON[ROUND-1]);
        shifted = shift_rows(sub_bytes(state_in));
        mixed   = FINAL_ROUND ? shifted : mix_columns(shifted);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_out     <= '0;
            round_key_out <= '0;
        end else begin
            state_out     <= mixed ^ rk_next;
            round_key_out <= rk_next;
        end
    end

endmodule

// File: rtl/aes128_top.sv
// Fully pipelined AES-128 encryption core, one block per clock, 11-cycle
// latency from sampling edge to cryptokey update. Each block travels with its
// own key, so the key schedule is expanded stage by stage alongside the data.
// Ports: clk, reset (async active-low), data_in (plaintext), key (cipher key),
// cryptokey (registered ciphertext). Bit 127 is byte 0 throughout.
module aes128_top
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] data_in,
    input  logic [127:0] key,
    output logic [127:0] cryptokey
);

    logic [127:0] state_0;
    logic [127:0] rkey_0;
    logic [127:0] stage_state [0:10];
    logic [127:0] stage_rkey  [0:10];

    // Input register performs the initial AddRoundKey with the raw key.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_0   <= '0;
            rkey_0    <= '0;
            cryptokey <= '0;
        end else begin
            state_0   <= data_in ^ key;
            rkey_0    <= key;
            cryptokey <= stage_state[10];
        end
    end

    assign stage_state[0] = state_0;
    assign stage_rkey[0]  = rkey_0;

    for (genvar r = 1; r <= 10; r++) begin : g_round
        aes_round_stage #(
            .ROUND       (r),
            .FINAL_ROUND (r == 10)
        ) u_stage (
            .clk           (clk),
            .reset         (reset),
            .state_in      (stage_state[r-1]),
            .round_key_in  (stage_rkey[r-1]),
            .state_out     (stage_state[r]),
            .round_key_out (stage_rkey[r])
        );
    end

endmodule

// File: tb/tb_aes128_top.sv
module tb_aes128_top;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [127:0] data_in = '0;
    logic [127:0] key = '0;
    logic [127:0] cryptokey;

    int n_err = 0;
    int n_checks = 0;

    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2 = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] K2  = 128'h0f1571c947d9e8590cb7add6af7f6798;
    localparam logic [127:0] CT2 = 128'hff0b844a0853bf7c6934ab4364148fb9;

    logic [7:0]   sbox_tab [256];
    logic [127:0] pend_q [$];

    aes128_top dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .key       (key),
        .cryptokey (cryptokey)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model (FIPS-197 from first principles) ----

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S(a) = affine(a^-1) over GF(2^8).
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            if (a != 0) begin
                for (int b = 1; b < 256; b++) begin
                    if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
                end
            end
            sbox_tab[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                          ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] w [176];
        logic [7:0] tmp [4];
        logic [7:0] rc, t0, a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            s[i] = pt[127 - 8*i -: 8];
            w[i] = k[127 - 8*i -: 8];
        end
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1) + j];
            if (i % 4 == 0) begin
                t0     = tmp[0];
                tmp[0] = sbox_tab[tmp[1]] ^ rc;
                tmp[1] = sbox_tab[tmp[2]];
                tmp[2] = sbox_tab[tmp[3]];
                tmp[3] = sbox_tab[t0];
                rc     = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[4*i + j] = w[4*(i-4) + j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c + row] = t[4*((c + row) % 4) + row];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r + i];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Starts and ends at a falling edge. Drives one pair, lets one rising edge
    // sample it, and returns the ciphertext the output should now show (the
    // pair sampled 11 edges earlier) once 12 samples have accumulated.
    task automatic drive_cycle(input logic [127:0] d, input logic [127:0] k,
                               output bit got, output logic [127:0] exp);
        data_in = d;
        key     = k;
        @(posedge clk);
        pend_q.push_back(ref_encrypt(d, k));
        got = 1'b0;
        exp = '0;
        if (pend_q.size() == 12) begin
            exp = pend_q.pop_front();
            got = 1'b1;
        end
        @(negedge clk);
    endtask

    // ---------------- tests ----------------

    task automatic test_reset();
        reset   = 1'b0;
        data_in = '0;
        key     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (cryptokey !== 128'h0) begin
            n_err++;
            $display("FAIL reset_held: got %h want %h", cryptokey, 128'h0);
        end
        reset = 1'b1;
        pend_q.delete();
        @(posedge clk);
        pend_q.push_back(ref_encrypt(128'h0, 128'h0));
        @(negedge clk);
        n_checks++;
        if (cryptokey !== 128'h0) begin
            n_err++;
            $display("FAIL reset_first_edge: got %h want %h", cryptokey, 128'h0);
        end
    endtask

    task automatic test_vector(input logic [127:0] pt, input logic [127:0] k,
                               input logic [127:0] ct, input string name);
        bit got;
        logic [127:0] exp;
        for (int i = 0; i < 12; i++) begin
            drive_cycle(pt, k, got, exp);
            if (got) begin
                n_checks++;
                if (cryptokey !== exp) begin
                    n_err++;
                    $display("FAIL %s_pipe[%0d]: got %h want %h", name, i, cryptokey, exp);
                end
            end
            if (i == 11) begin
                n_checks++;
                if (cryptokey !== ct) begin
                    n_err++;
                    $display("FAIL %s_kat: got %h want %h", name, cryptokey, ct);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit got;
        logic [127:0] exp;
        logic [127:0] want;
        for (int i = 0; i < 23; i++) begin
            if (i < 12 && (i % 2) == 0) drive_cycle(PT2, K2, got, exp);
            else                        drive_cycle(PT1, K1, got, exp);
            if (got) begin
                n_checks++;
                if (cryptokey !== exp) begin
                    n_err++;
                    $display("FAIL b2b_pipe[%0d]: got %h want %h", i, cryptokey, exp);
                end
            end
            if (i >= 11) begin
                want = ((i - 11) % 2 == 0) ? CT2 : CT1;
                n_checks++;
                if (cryptokey !== want) begin
                    n_err++;
                    $display("FAIL b2b_kat[%0d]: got %h want %h", i, cryptokey, want);
                end
            end
        end
    endtask

    task automatic test_latency();
        bit got;
        logic [127:0] exp;
        logic [127:0] pa, ka, pb, kb, ct_a, ct_b, want;
        pa = rand128(); ka = rand128();
        pb = rand128(); kb = rand128();
        ct_a = ref_encrypt(pa, ka);
        ct_b = ref_encrypt(pb, kb);
        for (int i = 0; i < 26; i++) begin
            if (i == 12) drive_cycle(pb, kb, got, exp);
            else         drive_cycle(pa, ka, got, exp);
            if (i >= 12 && i <= 24) begin
                want = (i == 23) ? ct_b : ct_a;
                n_checks++;
                if (cryptokey !== want) begin
                    n_err++;
                    $display("FAIL latency[%0d]: got %h want %h", i, cryptokey, want);
                end
            end
        end
    endtask

    task automatic test_random();
        bit got;
        logic [127:0] exp;
        for (int i = 0; i < 40; i++) begin
            drive_cycle(rand128(), rand128(), got, exp);
            if (got) begin
                n_checks++;
                if (cryptokey !== exp) begin
                    n_err++;
                    $display("FAIL random[%0d]: got %h want %h", i, cryptokey, exp);
                end
            end
        end
    endtask

    task automatic test_midstream_reset();
        bit got;
        logic [127:0] exp;
        for (int i = 0; i < 12; i++) drive_cycle(rand128(), rand128(), got, exp);
        data_in = PT1;
        key     = K1;
        reset   = 1'b0;
        #1;
        n_checks++;
        if (cryptokey !== 128'h0) begin
            n_err++;
            $display("FAIL midreset_async: got %h want %h", cryptokey, 128'h0);
        end
        #1;
        reset = 1'b1;
        pend_q.delete();
        for (int i = 0; i < 13; i++) begin
            drive_cycle(PT1, K1, got, exp);
            if (got) begin
                n_checks++;
                if (cryptokey !== exp) begin
                    n_err++;
                    $display("FAIL midreset_pipe[%0d]: got %h want %h", i, cryptokey, exp);
                end
            end
            if (i >= 11) begin
                n_checks++;
                if (cryptokey !== CT1) begin
                    n_err++;
                    $display("FAIL midreset_kat[%0d]: got %h want %h", i, cryptokey, CT1);
                end
            end
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_vector(PT1, K1, CT1, "fips");
        test_vector(PT2, K2, CT2, "second");
        test_back_to_back();
        test_latency();
        test_random();
        test_midstream_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
